// File: rtl/param_seq_detector.sv
// Runtime-programmable serial pattern detector: loadable pattern/length/overlap,
// valid-qualified input, registered one-cycle match strobe and saturating match count.
module param_seq_detector #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err,
  output logic               armed
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [LEN_W-1:0] MAXL = LEN_W'(MAX_LEN);

  state_t             state, state_nx;
  logic [MAX_LEN-1:0] pat_q, pat_nx;
  logic [MAX_LEN-1:0] hist_q, hist_nx;
  logic [MAX_LEN-1:0] nh, mask;
  logic [LEN_W-1:0]   len_q, len_nx;
  logic [LEN_W-1:0]   fill_q, fill_nx;
  logic               ovl_q, ovl_nx;
  logic               out_nx, err_nx;
  logic [CNT_W-1:0]   cnt_nx;
  logic               len_ok, fill_ok, hit;

  assign armed  = (state == RUN);
  assign len_ok = (cfg_len != '0) && (cfg_len <= MAXL);
  assign nh     = {hist_q[MAX_LEN-2:0], in};

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (i < 32'(len_q)) mask[i] = 1'b1;
    end
  end

  // fill+1 >= len, evaluated one bit wider so fill = MAX_LEN cannot wrap
  assign fill_ok = (({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q});
  assign hit     = fill_ok && (((nh ^ pat_q) & mask) == '0);

  always_comb begin
    state_nx = state;
    pat_nx   = pat_q;
    len_nx   = len_q;
    ovl_nx   = ovl_q;
    hist_nx  = hist_q;
    fill_nx  = fill_q;
    cnt_nx   = match_count;
    err_nx   = cfg_err;
    out_nx   = 1'b0;

    if (cfg_load) begin
      hist_nx = '0;
      fill_nx = '0;
      cnt_nx  = '0;
      if (len_ok) begin
        pat_nx   = cfg_pattern;
        len_nx   = cfg_len;
        ovl_nx   = cfg_overlap;
        err_nx   = 1'b0;
        state_nx = RUN;
      end else begin
        err_nx   = 1'b1;
        state_nx = IDLE;
      end
    end else if (state == RUN && in_valid) begin
      out_nx = hit;
      if (hit && match_count != '1) cnt_nx = match_count + CNT_W'(1);
      if (hit && !ovl_q) begin
        hist_nx = '0;
        fill_nx = '0;
      end else begin
        hist_nx = nh;
        fill_nx = (fill_q == MAXL) ? fill_q : fill_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
      hist_q      <= '0;
      fill_q      <= '0;
      out         <= 1'b0;
      match_count <= '0;
      cfg_err     <= 1'b0;
    end else begin
      state       <= state_nx;
      pat_q       <= pat_nx;
      len_q       <= len_nx;
      ovl_q       <= ovl_nx;
      hist_q      <= hist_nx;
      fill_q      <= fill_nx;
      out         <= out_nx;
      match_count <= cnt_nx;
      cfg_err     <= err_nx;
    end
  end

endmodule

// File: tb/tb_param_seq_detector.sv
// Directed bench for param_seq_detector (MAX_LEN=8, CNT_W=4) with an
// expected-result queue filled at drive time and drained after each edge.
module tb_param_seq_detector;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 4;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rst;
  logic               in;
  logic               in_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               out;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;
  logic               armed;

  param_seq_detector #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .out(out), .match_count(match_count), .cfg_err(cfg_err), .armed(armed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             o;
    logic [CNT_W-1:0] c;
    logic             a;
    logic             e;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   step  = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step, obs, expv);
    end
  endtask

  // Push expectation for the coming edge, clock once, pop and compare.
  task automatic cyc(input logic eo, input int ec, input logic ea, input logic ee);
    exp_t e;
    exp_q.push_back('{o: eo, c: CNT_W'(ec), a: ea, e: ee});
    @(posedge clk);
    #1;
    step++;
    e = exp_q.pop_front();
    chk("out",         {7'd0, out},         {7'd0, e.o});
    chk("match_count", {4'd0, match_count}, {4'd0, e.c});
    chk("armed",       {7'd0, armed},       {7'd0, e.a});
    chk("cfg_err",     {7'd0, cfg_err},     {7'd0, e.e});
  endtask

  task automatic bitv(input logic b, input logic eo, input int ec, input logic ea, input logic ee);
    cfg_load = 1'b0;
    in_valid = 1'b1;
    in       = b;
    cyc(eo, ec, ea, ee);
  endtask

  task automatic gap(input int ec, input logic ea, input logic ee);
    cfg_load = 1'b0;
    in_valid = 1'b0;
    cyc(1'b0, ec, ea, ee);
  endtask

  task automatic load(input logic [7:0] p, input logic [LEN_W-1:0] l, input logic ov,
                      input logic v, input logic b, input logic ea, input logic ee);
    cfg_load    = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = ov;
    in_valid    = v;
    in          = b;
    cyc(1'b0, 0, ea, ee);
    cfg_load    = 1'b0;
    in_valid    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog step=%0d observed=timeout expected=finish", step);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a5;
    a5 = 8'hA5;
    rst = 1'b1; in = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;

    // Reset and idle
    cyc(1'b0, 0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) bitv(1'($urandom), 1'b0, 0, 1'b0, 1'b0);

    // Overlap on: 1011011 -> hits after bits 4 and 7
    load(8'b1011, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    bitv(1, 0, 0, 1, 0); bitv(0, 0, 0, 1, 0); bitv(1, 0, 0, 1, 0); bitv(1, 1, 1, 1, 0);
    bitv(0, 0, 1, 1, 0); bitv(1, 0, 1, 1, 0); bitv(1, 1, 2, 1, 0);

    // Overlap off: history cleared after first hit
    load(8'b1011, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    bitv(1, 0, 0, 1, 0); bitv(0, 0, 0, 1, 0); bitv(1, 0, 0, 1, 0); bitv(1, 1, 1, 1, 0);
    bitv(0, 0, 1, 1, 0); bitv(1, 0, 1, 1, 0); bitv(1, 0, 1, 1, 0);

    // Valid gaps, then cfg_load with a bit that would otherwise complete a match
    load(8'b1011, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    bitv(1, 0, 0, 1, 0); bitv(0, 0, 0, 1, 0);
    gap(0, 1, 0); gap(0, 1, 0); gap(0, 1, 0);
    bitv(1, 0, 0, 1, 0); bitv(1, 1, 1, 1, 0);
    bitv(1, 0, 1, 1, 0); bitv(0, 0, 1, 1, 0); bitv(1, 0, 1, 1, 0);
    load(8'b1011, 4'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    bitv(1, 0, 0, 1, 0);

    // Illegal lengths: 0 and MAX_LEN+1
    load(8'b1011, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    bitv(1, 0, 0, 0, 1); bitv(0, 0, 0, 0, 1); bitv(1, 0, 0, 0, 1); bitv(1, 0, 0, 0, 1);
    load(8'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    bitv(1, 0, 0, 0, 1);

    // len = 1 all-ones: out every cycle, count saturates at 15
    load(8'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 20; i++) bitv(1, 1, (i > 15) ? 15 : i, 1, 0);
    gap(15, 1, 0);

    // Reset mid-stream (also wins over a simultaneous cfg_load), then full A5
    load(8'hA5, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 7; i >= 3; i--) bitv(a5[i], 0, 0, 1, 0);
    rst = 1'b1; cfg_load = 1'b1; cfg_len = 4'd8; in_valid = 1'b1; in = a5[2];
    cyc(1'b0, 0, 1'b0, 1'b0);
    rst = 1'b0; cfg_load = 1'b0;
    for (int i = 2; i >= 0; i--) bitv(a5[i], 0, 0, 0, 0);
    load(8'hA5, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 7; i >= 1; i--) bitv(a5[i], 0, 0, 1, 0);
    bitv(a5[0], 1, 1, 1, 0);
    gap(1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
